// File: rtl/mul_add_pipe_if.sv
// mul_add_pipe_if: operand/result stream bundle for mul_add_pipe.
//   master : producer/consumer side (drives operands, in_valid, out_ready)
//   slave  : pipeline side (drives in_ready, out_valid, out, out_tag)
// Signals: in_valid/in_ready, x, y, z, in_tag, out_valid/out_ready, out, out_tag.
interface mul_add_pipe_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] z;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, x, y, z, in_tag, out_ready,
      input  in_ready, out_valid, out, out_tag
   );

   modport slave (
      input  in_valid, x, y, z, in_tag, out_ready,
      output in_ready, out_valid, out, out_tag
   );
endinterface

// File: rtl/mul_add_pipe.sv
// mul_add_pipe: out = (x*y truncated to WIDTH) + z over an input register
// followed by STAGES compute registers, with valid/ready flow control and a
// tag carried alongside each operand set.
//
// Parameters: WIDTH (operand/result bits), STAGES (compute stages, >=1),
//             TAG_W (sideband tag bits).
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset, clears every register
//   bus  - mul_add_pipe_if.slave: in_valid/in_ready, x, y, z, in_tag,
//          out_valid/out_ready, out, out_tag
//
// Build option: define MUL_ADD_PIPE_SAT_EN to make the final add saturate
// at 2^WIDTH-1 instead of wrapping. Timing and handshake are unchanged.
module mul_add_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int TAG_W  = 4
) (
   input  logic          clk,
   input  logic          rst,
   mul_add_pipe_if.slave bus
);

   // input register
   logic             v0_q, v0_d;
   logic [WIDTH-1:0] x0_q, x0_d;
   logic [WIDTH-1:0] y0_q, y0_d;
   logic [WIDTH-1:0] z0_q, z0_d;
   logic [TAG_W-1:0] t0_q, t0_d;

   // compute stages 1..STAGES; a_* holds the product, or the sum in the
   // last stage. zc_* carries the addend up to the adding stage.
   logic             v_q  [1:STAGES];
   logic             v_d  [1:STAGES];
   logic [WIDTH-1:0] a_q  [1:STAGES];
   logic [WIDTH-1:0] a_d  [1:STAGES];
   logic [WIDTH-1:0] zc_q [1:STAGES];
   logic [WIDTH-1:0] zc_d [1:STAGES];
   logic [TAG_W-1:0] t_q  [1:STAGES];
   logic [TAG_W-1:0] t_d  [1:STAGES];

   logic             en;
   logic [WIDTH-1:0] prod0;
   logic             v_prev;
   logic [WIDTH-1:0] p_prev;
   logic [WIDTH-1:0] z_prev;
   logic [TAG_W-1:0] t_prev;

   // WIDTH-bit context keeps only the low half of the product
   assign prod0 = x0_q * y0_q;

   function automatic logic [WIDTH-1:0] add_f(input logic [WIDTH-1:0] p,
                                              input logic [WIDTH-1:0] a);
`ifdef MUL_ADD_PIPE_SAT_EN
      logic [WIDTH:0] s;
      s = {1'b0, p} + {1'b0, a};
      return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
`else
      return p + a;
`endif
   endfunction

   always_comb begin
      // whole pipe advances only when the output slot is free or draining
      en     = !v_q[STAGES] || bus.out_ready;
      v0_d   = v0_q;
      x0_d   = x0_q;
      y0_d   = y0_q;
      z0_d   = z0_q;
      t0_d   = t0_q;
      v_d    = v_q;
      a_d    = a_q;
      zc_d   = zc_q;
      t_d    = t_q;
      v_prev = v0_q;
      p_prev = prod0;
      z_prev = z0_q;
      t_prev = t0_q;
      if (en) begin
         v0_d = bus.in_valid;
         x0_d = bus.x;
         y0_d = bus.y;
         z0_d = bus.z;
         t0_d = bus.in_tag;
         // walk the stages, each loading what its predecessor held
         for (int s = 1; s <= STAGES; s++) begin
            v_d[s] = v_prev;
            t_d[s] = t_prev;
            if (s == STAGES) begin
               a_d[s] = add_f(p_prev, z_prev);
            end else begin
               a_d[s]  = p_prev;
               zc_d[s] = z_prev;
            end
            v_prev = v_q[s];
            p_prev = a_q[s];
            z_prev = zc_q[s];
            t_prev = t_q[s];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v0_q <= 1'b0;
         x0_q <= '0;
         y0_q <= '0;
         z0_q <= '0;
         t0_q <= '0;
         for (int s = 1; s <= STAGES; s++) begin
            v_q[s]  <= 1'b0;
            a_q[s]  <= '0;
            zc_q[s] <= '0;
            t_q[s]  <= '0;
         end
      end else begin
         v0_q <= v0_d;
         x0_q <= x0_d;
         y0_q <= y0_d;
         z0_q <= z0_d;
         t0_q <= t0_d;
         v_q  <= v_d;
         a_q  <= a_d;
         zc_q <= zc_d;
         t_q  <= t_d;
      end
   end

   assign bus.in_ready  = en;
   assign bus.out_valid = v_q[STAGES];
   assign bus.out       = a_q[STAGES];
   assign bus.out_tag   = t_q[STAGES];

endmodule
